// File: rtl/issue_ctrl_if.sv
// Decode-to-issue handshake, completion/branch report and status outputs of issue_ctrl.
// slave = issue_ctrl side, master = decode/execute environment side.
interface issue_ctrl_if;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        uses_rs2;
  logic        writes_rd;
  logic        is_branch;
  logic        exe_ready;
  logic        cpl_valid;
  logic        cpl_write;
  logic [4:0]  cpl_rd;
  logic        branch_done;
  logic [31:0] busy;
  logic [2:0]  inflight;
  logic        wait_branch;
  logic [31:0] stall_cnt;
  logic        err;

  modport slave (
    input  dec_valid, rs1, rs2, rd, uses_rs2, writes_rd, is_branch,
    input  exe_ready, cpl_valid, cpl_write, cpl_rd, branch_done,
    output dec_ready, busy, inflight, wait_branch, stall_cnt, err
  );

  modport master (
    output dec_valid, rs1, rs2, rd, uses_rs2, writes_rd, is_branch,
    output exe_ready, cpl_valid, cpl_write, cpl_rd, branch_done,
    input  dec_ready, busy, inflight, wait_branch, stall_cnt, err
  );
endinterface

// File: rtl/issue_ctrl.sv
// In-order issue control: register scoreboard, inflight limit and branch hold.
// dec_ready is combinational (zero latency); decode is held off on hazard, full window, execute stall or unresolved branch.
module issue_ctrl #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  issue_ctrl_if.slave bus
);

  typedef enum logic {RUN = 1'b0, WAIT_BR = 1'b1} state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);

  state_t      state;
  logic [31:0] busy_q;
  logic [31:0] busy_nxt;
  logic [2:0]  inflight_q;
  logic [31:0] stall_q;
  logic        wait_q;
  logic        err_q;
  logic        hazard;
  logic        issue;
  logic        cpl_dec;
  logic        err_set;

  // Hazards look only at the registered scoreboard; a completion this cycle is not bypassed.
  always_comb begin
    hazard = 1'b0;
    if (bus.rs1 != 5'd0 && busy_q[bus.rs1])
      hazard = 1'b1;
    if (bus.uses_rs2 && bus.rs2 != 5'd0 && busy_q[bus.rs2])
      hazard = 1'b1;
    if (bus.writes_rd && bus.rd != 5'd0 && busy_q[bus.rd])
      hazard = 1'b1;
  end

  assign issue = bus.dec_valid && (state == RUN) && !hazard && bus.exe_ready
                 && (inflight_q < MAX_CNT);

  // A completion with nothing outstanding is flagged but must not underflow the count.
  assign cpl_dec = bus.cpl_valid && (inflight_q != 3'd0);

  assign err_set = (bus.cpl_valid && inflight_q == 3'd0)
                || (bus.cpl_valid && bus.cpl_write && bus.cpl_rd != 5'd0 && !busy_q[bus.cpl_rd])
                || (bus.branch_done && state == RUN);

  always_comb begin
    busy_nxt = busy_q;
    if (bus.cpl_valid && bus.cpl_write && bus.cpl_rd != 5'd0)
      busy_nxt[bus.cpl_rd] = 1'b0;
    if (issue && bus.writes_rd && bus.rd != 5'd0)
      busy_nxt[bus.rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      wait_q     <= 1'b0;
      busy_q     <= 32'd0;
      inflight_q <= 3'd0;
      stall_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      busy_q <= busy_nxt;

      case ({issue, cpl_dec})
        2'b10:   inflight_q <= inflight_q + 3'd1;
        2'b01:   inflight_q <= inflight_q - 3'd1;
        default: inflight_q <= inflight_q;
      endcase

      if (bus.dec_valid && !issue && stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;

      if (err_set)
        err_q <= 1'b1;

      case (state)
        RUN: begin
          if (issue && bus.is_branch) begin
            state  <= WAIT_BR;
            wait_q <= 1'b1;
          end
        end
        WAIT_BR: begin
          if (bus.branch_done) begin
            state  <= RUN;
            wait_q <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          wait_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dec_ready   = issue;
  assign bus.busy        = busy_q;
  assign bus.inflight    = inflight_q;
  assign bus.wait_branch = wait_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed scenarios followed by randomized traffic, all checked against a rule-level model.
module tb_issue_ctrl;
  localparam int MAXI = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_ctrl_if bus();
  issue_ctrl #(.MAX_INFLIGHT(MAXI)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Reference model: set of registers awaiting writeback, outstanding count, branch hold.
  bit              pend[32];
  int              cnt;
  bit              in_br;
  longint unsigned stalls;
  bit              m_err;
  logic            last_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_rdy();
    bit haz;
    haz = (bus.rs1 != 0 && pend[bus.rs1])
       || (bus.uses_rs2 && bus.rs2 != 0 && pend[bus.rs2])
       || (bus.writes_rd && bus.rd != 0 && pend[bus.rd]);
    return bus.dec_valid && !in_br && bus.exe_ready && !haz && (cnt < MAXI);
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 1; i < 32; i++) v[i] = pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    cnt = 0; in_br = 1'b0; stalls = 0; m_err = 1'b0;
  endtask

  task automatic model_step(input bit iss);
    bit old_br;
    if (rst) begin
      model_reset();
      return;
    end
    old_br = in_br;
    if (bus.cpl_valid) begin
      if (cnt == 0) m_err = 1'b1;
      else cnt--;
      if (bus.cpl_write && bus.cpl_rd != 0) begin
        if (!pend[bus.cpl_rd]) m_err = 1'b1;
        pend[bus.cpl_rd] = 1'b0;
      end
    end
    if (bus.branch_done) begin
      if (old_br) in_br = 1'b0;
      else m_err = 1'b1;
    end
    if (iss) begin
      cnt++;
      if (bus.writes_rd && bus.rd != 0) pend[bus.rd] = 1'b1;
      if (bus.is_branch) in_br = 1'b1;
    end
    if (bus.dec_valid && !iss && stalls != 64'hFFFF_FFFF) stalls++;
  endtask

  // One clock: dec_ready is checked mid-cycle, registered outputs just after the edge.
  task automatic cyc();
    bit er;
    @(negedge clk);
    er = model_rdy();
    last_rdy = bus.dec_ready;
    if (!rst) check("dec_ready", bus.dec_ready, {31'd0, er});
    @(posedge clk);
    model_step(er);
    #1;
    check("busy", bus.busy, pend_vec());
    check("inflight", {29'd0, bus.inflight}, cnt);
    check("wait_branch", {31'd0, bus.wait_branch}, {31'd0, in_br});
    check("stall_cnt", bus.stall_cnt, stalls[31:0]);
    check("err", {31'd0, bus.err}, {31'd0, m_err});
  endtask

  task automatic idle();
    bus.dec_valid = 0; bus.rs1 = 0; bus.rs2 = 0; bus.rd = 0;
    bus.uses_rs2 = 0; bus.writes_rd = 0; bus.is_branch = 0; bus.exe_ready = 1;
    bus.cpl_valid = 0; bus.cpl_write = 0; bus.cpl_rd = 0; bus.branch_done = 0;
  endtask

  task automatic dec(input int r1, input int r2, input int d, input bit u2, input bit wr, input bit br);
    bus.dec_valid = 1; bus.rs1 = 5'(r1); bus.rs2 = 5'(r2); bus.rd = 5'(d);
    bus.uses_rs2 = u2; bus.writes_rd = wr; bus.is_branch = br;
  endtask

  task automatic nodec();
    bus.dec_valid = 0;
  endtask

  task automatic cpl(input int d, input bit wr);
    bus.cpl_valid = 1; bus.cpl_write = wr; bus.cpl_rd = 5'(d);
  endtask

  task automatic nocpl();
    bus.cpl_valid = 0; bus.cpl_write = 0; bus.cpl_rd = 0;
  endtask

  initial begin
    int q[$];
    model_reset();
    idle();
    rst = 1;
    #1;
    cyc();
    cyc();
    rst = 0;
    check("rst_busy", bus.busy, 32'd0);
    check("rst_inflight", {29'd0, bus.inflight}, 32'd0);
    check("rst_stall", bus.stall_cnt, 32'd0);

    // RAW hazard on x5
    dec(1, 2, 5, 1, 1, 0); cyc();
    check("raw_busy5", bus.busy, 32'h0000_0020);
    dec(5, 0, 6, 0, 1, 0); cyc();
    check("raw_stall_rdy", {31'd0, last_rdy}, 32'd0);
    check("raw_stall_cnt", bus.stall_cnt, 32'd1);
    cpl(5, 1); cyc();
    check("raw_no_bypass", {31'd0, last_rdy}, 32'd0);
    nocpl(); cyc();
    check("raw_issue_after_cpl", {31'd0, last_rdy}, 32'd1);
    nodec(); cpl(6, 1); cyc(); nocpl();

    // x0 never becomes busy
    dec(0, 0, 0, 0, 1, 0); cyc();
    check("x0_busy", bus.busy, 32'd0);
    check("x0_inflight", {29'd0, bus.inflight}, 32'd1);
    cyc();
    check("x0_no_stall", {31'd0, last_rdy}, 32'd1);
    nodec(); cpl(0, 0); cyc(); cyc(); nocpl();
    check("x0_drained", {29'd0, bus.inflight}, 32'd0);

    // inflight limit
    for (int i = 0; i < 4; i++) begin dec(0, 0, 10 + i, 0, 1, 0); cyc(); end
    dec(0, 0, 14, 0, 1, 0); cyc();
    check("limit_stall", {31'd0, last_rdy}, 32'd0);
    cpl(10, 1); cyc(); nocpl(); cyc();
    check("limit_issue", {31'd0, last_rdy}, 32'd1);
    check("limit_inflight", {29'd0, bus.inflight}, 32'd4);
    nodec();
    for (int i = 11; i < 15; i++) begin cpl(i, 1); cyc(); end
    nocpl();

    // branch hold
    dec(1, 0, 0, 0, 0, 1); cyc();
    check("br_wait", {31'd0, bus.wait_branch}, 32'd1);
    dec(1, 0, 20, 0, 1, 0); cyc();
    check("br_stall", {31'd0, last_rdy}, 32'd0);
    bus.branch_done = 1; cyc(); bus.branch_done = 0;
    check("br_release", {31'd0, bus.wait_branch}, 32'd0);
    cyc();
    check("br_resume", {31'd0, last_rdy}, 32'd1);
    nodec(); cpl(0, 0); cyc(); cpl(20, 1); cyc(); nocpl();

    // simultaneous issue and completion, then spurious completion
    dec(0, 0, 1, 0, 1, 0); cyc();
    dec(0, 0, 2, 0, 1, 0); cyc();
    dec(0, 0, 3, 0, 1, 0); cpl(1, 1); cyc();
    check("simul_inflight", {29'd0, bus.inflight}, 32'd2);
    nodec(); cpl(2, 1); cyc(); cpl(3, 1); cyc();
    check("pre_spurious_err", {31'd0, bus.err}, 32'd0);
    cpl(0, 0); cyc(); nocpl();
    check("spurious_err", {31'd0, bus.err}, 32'd1);
    check("spurious_inflight", {29'd0, bus.inflight}, 32'd0);

    // reset mid-operation with conflicting activity in the reset cycle
    rst = 1; cyc(); rst = 0;
    dec(0, 0, 5, 0, 1, 0); cyc();
    dec(0, 0, 6, 0, 1, 0); cyc();
    dec(0, 0, 0, 0, 0, 1); cyc();
    check("mid_busy", bus.busy, 32'h0000_0060);
    check("mid_inflight", {29'd0, bus.inflight}, 32'd3);
    check("mid_wait", {31'd0, bus.wait_branch}, 32'd1);
    rst = 1; dec(0, 0, 7, 0, 1, 0); cpl(5, 1); bus.branch_done = 1; cyc();
    rst = 0; idle();
    check("rst_mid_busy", bus.busy, 32'd0);
    check("rst_mid_inflight", {29'd0, bus.inflight}, 32'd0);
    check("rst_mid_wait", {31'd0, bus.wait_branch}, 32'd0);
    check("rst_mid_stall", bus.stall_cnt, 32'd0);
    check("rst_mid_err", {31'd0, bus.err}, 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 70)
        dec($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0));
      else
        nodec();
      bus.exe_ready = ($urandom_range(0, 99) < 85);
      nocpl();
      if (cnt > 0 && $urandom_range(0, 99) < 40) begin
        q.delete();
        for (int i = 1; i < 32; i++) if (pend[i]) q.push_back(i);
        if (q.size() > 0 && $urandom_range(0, 9) < 7)
          cpl(q[$urandom_range(0, q.size() - 1)], 1);
        else
          cpl(0, 0);
      end else if ($urandom_range(0, 99) == 0) begin
        cpl($urandom_range(0, 7), 1'($urandom_range(0, 1)));
      end
      if (in_br) bus.branch_done = ($urandom_range(0, 9) < 3);
      else bus.branch_done = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 0;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
